// File: rtl/snk68_pkg.sv
// Shared constants and types for the SNK68 68K bus glue.
// Holds the responder state encoding and the default wait-state figures.
package snk68_pkg;

   localparam int unsigned CNT_W        = 8;
   localparam int unsigned DEF_RAM_WAIT = 1;
   localparam int unsigned DEF_IO_WAIT  = 0;
   localparam int unsigned DEF_TIMEOUT  = 63;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ROM_WAIT = 3'd1,
      FIX_WAIT = 3'd2,
      TMO_WAIT = 3'd3,
      ACK      = 3'd4
   } bus_state_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with a zero flag, used for fixed wait states and
// the unmapped-access timeout. Saturates at zero.
module wait_counter
   import snk68_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign count = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/m68k_bus_responder.sv
// 68K DTACK generator: ROM accesses handshake with SDRAM via a toggle pair,
// fixed regions use wait states, unmapped accesses time out and self-ack.
module m68k_bus_responder
   import snk68_pkg::*;
#(
   parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
   parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic m68k_as_n,
   input  logic m68k_rw,
   input  logic rom_cs,
   input  logic mem_cs,
   input  logic io_cs,
   input  logic rom_ack,
   output logic rom_req,
   output logic m68k_dtack_n,
   output logic unmapped
);

   bus_state_t       state_q, state_d;
   logic             rom_req_q, rom_req_d;
   logic             pending_q, pending_d;
   logic             dtack_n_q;
   logic             unmapped_q, unmapped_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic [CNT_W-1:0] unused_cnt;
   logic             unused_rw;

   // Reads and writes share timing, so the direction line is not consulted.
   assign unused_rw = m68k_rw;

   wait_counter u_wait_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (unused_cnt),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      rom_req_d    = rom_req_q;
      pending_d    = pending_q;
      unmapped_d   = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!m68k_as_n) begin
               if (rom_cs) begin
                  // An abandoned fetch must complete before a new toggle is issued.
                  if (!pending_q || (rom_ack == rom_req_q)) begin
                     rom_req_d = ~rom_req_q;
                     pending_d = 1'b0;
                     state_d   = ROM_WAIT;
                  end
               end else if (mem_cs) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = CNT_W'(RAM_WAIT);
                  state_d      = FIX_WAIT;
               end else if (io_cs) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = CNT_W'(IO_WAIT);
                  state_d      = FIX_WAIT;
               end else begin
                  cnt_load     = 1'b1;
                  cnt_load_val = CNT_W'(TIMEOUT);
                  state_d      = TMO_WAIT;
               end
            end
         end
         ROM_WAIT: begin
            if (m68k_as_n) begin
               pending_d = 1'b1;
               state_d   = IDLE;
            end else if (rom_ack == rom_req_q) begin
               state_d = ACK;
            end
         end
         FIX_WAIT: begin
            if (m68k_as_n) begin
               state_d = IDLE;
            end else if (cnt_zero) begin
               state_d = ACK;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         TMO_WAIT: begin
            if (m68k_as_n) begin
               state_d = IDLE;
            end else if (cnt_zero) begin
               unmapped_d = 1'b1;
               state_d    = ACK;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ACK: begin
            if (m68k_as_n) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // DTACK is registered from the next state so it tracks ACK with no comb path.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rom_req_q  <= 1'b0;
         pending_q  <= 1'b0;
         dtack_n_q  <= 1'b1;
         unmapped_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_req_q  <= rom_req_d;
         pending_q  <= pending_d;
         dtack_n_q  <= (state_d != ACK);
         unmapped_q <= unmapped_d;
      end
   end

   assign rom_req      = rom_req_q;
   assign m68k_dtack_n = dtack_n_q;
   assign unmapped     = unmapped_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: IO, RAM, ROM, timeout, ROM abort
// and asynchronous reset scenarios with hand-derived edge timing.
module tb_m68k_bus_responder;

   logic clk = 1'b0;
   logic reset_n;
   logic m68k_as_n, m68k_rw;
   logic rom_cs, mem_cs, io_cs;
   logic rom_ack;
   logic rom_req, m68k_dtack_n, unmapped;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   m68k_bus_responder #(
      .RAM_WAIT (1),
      .IO_WAIT  (0),
      .TIMEOUT  (63)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .m68k_as_n    (m68k_as_n),
      .m68k_rw      (m68k_rw),
      .rom_cs       (rom_cs),
      .mem_cs       (mem_cs),
      .io_cs        (io_cs),
      .rom_ack      (rom_ack),
      .rom_req      (rom_req),
      .m68k_dtack_n (m68k_dtack_n),
      .unmapped     (unmapped)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      m68k_as_n = 1'b1;
      rom_cs    = 1'b0;
      mem_cs    = 1'b0;
      io_cs     = 1'b0;
   endtask

   initial begin
      logic seen;
      reset_n = 1'b0;
      m68k_rw = 1'b1;
      rom_ack = 1'b0;
      bus_idle();
      tick();
      tick();
      check_eq("rst_dtack", m68k_dtack_n, 1);
      check_eq("rst_req", rom_req, 0);
      check_eq("rst_unmapped", unmapped, 0);
      reset_n = 1'b1;
      tick();

      // IO read: dtack at T+1, released on the edge sampling as_n high
      m68k_as_n = 1'b0; io_cs = 1'b1; m68k_rw = 1'b1;
      tick();
      check_eq("io_T0_dtack", m68k_dtack_n, 1);
      tick();
      check_eq("io_T1_dtack", m68k_dtack_n, 0);
      tick();
      check_eq("io_T2_dtack", m68k_dtack_n, 0);
      bus_idle();
      tick();
      check_eq("io_T3_dtack", m68k_dtack_n, 1);
      check_eq("io_unmapped", unmapped, 0);
      tick();

      // RAM write; selects swap to ROM after decode and must be ignored
      m68k_as_n = 1'b0; mem_cs = 1'b1; m68k_rw = 1'b0;
      tick();
      check_eq("ram_T0_dtack", m68k_dtack_n, 1);
      mem_cs = 1'b0; rom_cs = 1'b1;
      tick();
      check_eq("ram_T1_dtack", m68k_dtack_n, 1);
      tick();
      check_eq("ram_T2_dtack", m68k_dtack_n, 0);
      check_eq("ram_req", rom_req, 0);
      bus_idle();
      tick();
      check_eq("ram_rel_dtack", m68k_dtack_n, 1);
      tick();

      // ROM fetch: toggle at T, ack presented after T+5, dtack at T+6
      m68k_as_n = 1'b0; rom_cs = 1'b1; m68k_rw = 1'b1;
      tick();
      check_eq("rom_T0_req", rom_req, 1);
      check_eq("rom_T0_dtack", m68k_dtack_n, 1);
      seen = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         seen |= ~m68k_dtack_n;
      end
      check_eq("rom_early_dtack", seen, 0);
      rom_ack = 1'b1;
      tick();
      check_eq("rom_T6_dtack", m68k_dtack_n, 0);
      bus_idle();
      tick();
      check_eq("rom_rel_dtack", m68k_dtack_n, 1);
      check_eq("rom_rel_req", rom_req, 1);
      tick();

      // Unmapped: pulse and dtack at T+64
      m68k_as_n = 1'b0;
      tick();
      seen = 1'b0;
      for (int i = 1; i <= 63; i++) begin
         tick();
         seen |= unmapped | ~m68k_dtack_n;
      end
      check_eq("tmo_early", seen, 0);
      tick();
      check_eq("tmo_T64_unmapped", unmapped, 1);
      check_eq("tmo_T64_dtack", m68k_dtack_n, 0);
      tick();
      check_eq("tmo_T65_unmapped", unmapped, 0);
      check_eq("tmo_T65_dtack", m68k_dtack_n, 0);
      bus_idle();
      tick();
      check_eq("tmo_rel_dtack", m68k_dtack_n, 1);
      tick();

      // ROM abort with a late ack, then a retry that must wait for it
      m68k_as_n = 1'b0; rom_cs = 1'b1;
      tick();
      check_eq("abt_T0_req", rom_req, 0);
      tick();
      bus_idle();
      tick();
      check_eq("abt_dtack", m68k_dtack_n, 1);
      m68k_as_n = 1'b0; rom_cs = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen |= rom_req | ~m68k_dtack_n;
      end
      check_eq("abt_hold", seen, 0);
      rom_ack = 1'b0;
      tick();
      check_eq("abt_retoggle", rom_req, 1);
      check_eq("abt_retoggle_dtack", m68k_dtack_n, 1);
      rom_ack = 1'b1;
      tick();
      check_eq("abt_dtack_ack", m68k_dtack_n, 0);
      bus_idle();
      tick();
      check_eq("abt_rel_dtack", m68k_dtack_n, 1);
      tick();

      // Reset during ACK releases dtack without waiting for a clock edge
      m68k_as_n = 1'b0; io_cs = 1'b1;
      tick();
      tick();
      check_eq("rsta_pre_dtack", m68k_dtack_n, 0);
      check_eq("rsta_pre_req", rom_req, 1);
      #2;
      reset_n = 1'b0;
      rom_ack = 1'b0;
      #1;
      check_eq("rsta_dtack", m68k_dtack_n, 1);
      check_eq("rsta_req", rom_req, 0);
      check_eq("rsta_unmapped", unmapped, 0);
      bus_idle();
      tick();
      reset_n = 1'b1;
      tick();
      m68k_as_n = 1'b0; mem_cs = 1'b1;
      tick();
      tick();
      check_eq("rsta_ram_T1", m68k_dtack_n, 1);
      tick();
      check_eq("rsta_ram_T2", m68k_dtack_n, 0);
      bus_idle();
      tick();
      m68k_as_n = 1'b0; rom_cs = 1'b1;
      tick();
      check_eq("rsta_rom_req", rom_req, 1);
      rom_ack = 1'b1;
      tick();
      check_eq("rsta_rom_dtack", m68k_dtack_n, 0);
      bus_idle();
      tick();
      check_eq("rsta_rom_rel", m68k_dtack_n, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/m68k_bus_responder.md
M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 1: wait cycles for RAM, sprite, palette and FG RAM accesses.
REQ-002 SHALL have parameter IO_WAIT, default 0: wait cycles for input, DSW, rotary, latch and flip accesses.
REQ-003 SHALL have parameter TIMEOUT, default 63: cycles before an unmapped access is auto-acknowledged.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock; one clock only.
- reset_n  in  1  reset, asynchronous, active-low.
- m68k_as_n  in  1  68K address strobe.
- m68k_rw  in  1  68K read/write, 1 = read.
- rom_cs  in  1  OR of both program ROM selects.
- mem_cs  in  1  OR of RAM, sprite, palette and FG RAM selects.
- io_cs  in  1  OR of input, DSW, rotary, latch, invert-control, spr_flip and z80_latch_read selects.
- rom_ack  in  1  SDRAM toggle acknowledge.
- rom_req  out  1  SDRAM toggle request.
- m68k_dtack_n  out  1  68K data acknowledge.
- unmapped  out  1  one-cycle pulse on a timed-out access.

Function
REQ-005 SHALL implement FSM states IDLE, ROM_WAIT, FIX_WAIT, TMO_WAIT, ACK.
REQ-006 In IDLE, when m68k_as_n is sampled low, SHALL decode by priority rom_cs > mem_cs > io_cs > none.
REQ-007 On rom_cs, SHALL toggle rom_req on that edge and enter ROM_WAIT.
REQ-008 ROM_WAIT SHALL exit to ACK on the first edge where rom_ack equals rom_req.
REQ-009 On mem_cs, SHALL load the wait counter with RAM_WAIT and enter FIX_WAIT.
REQ-010 On io_cs, SHALL load the wait counter with IO_WAIT and enter FIX_WAIT.
REQ-011 FIX_WAIT SHALL decrement the counter each cycle and enter ACK when it is 0.
REQ-012 With no select active, SHALL load the counter with TIMEOUT and enter TMO_WAIT; the counter SHALL be 8 bits wide.
REQ-013 When the TMO_WAIT counter reaches 0, SHALL pulse unmapped for exactly 1 cycle and enter ACK.
REQ-014 m68k_dtack_n SHALL be low only in ACK and SHALL be registered.
REQ-015 Latency from the edge sampling m68k_as_n low to dtack low SHALL be WAIT+1 edges for fixed regions: IO_WAIT=0 gives 1 edge, RAM_WAIT=1 gives 2 edges.
REQ-016 ACK SHALL hold until m68k_as_n is sampled high, then return to IDLE with dtack high on that same edge.
REQ-017 A new access SHALL NOT be accepted in the same cycle that ACK exits; IDLE needs m68k_as_n low on a later edge.
REQ-018 If m68k_as_n rises during FIX_WAIT or TMO_WAIT, SHALL abort to IDLE with no dtack and no unmapped pulse.
REQ-019 If m68k_as_n rises during ROM_WAIT, SHALL abort to IDLE and set rom_pending.
REQ-020 While rom_pending is set, a new rom_cs access SHALL stay in IDLE until rom_ack equals rom_req, then clear rom_pending and issue a fresh toggle.
REQ-021 Changes to select inputs after decode SHALL be ignored until the FSM returns to IDLE.
REQ-022 The FSM SHALL NOT depend on m68k_rw; reads and writes SHALL have identical timing.

Reset
REQ-023 While reset_n is low, SHALL hold: state IDLE, m68k_dtack_n 1, rom_req 0, unmapped 0, counter 0, rom_pending 0.
REQ-024 Reset asserted mid-access SHALL release dtack immediately (asynchronously).
REQ-025 The SDRAM controller SHALL share the same reset, so that rom_ack=0 matches rom_req=0 after reset.

Structure
REQ-026 The state encoding and default wait constants SHALL live in the shared package snk68_pkg.
REQ-027 There SHALL be one sub-module, wait_counter: loadable 8-bit down-counter with a zero flag.
REQ-028 Select inputs SHALL be assumed synchronous to clk; no synchronizers SHALL be inside this block.

Verification
REQ-029 IO read: as_n low with io_cs=1 at edge T -> dtack_n low at T+1; as_n high at T+3 -> dtack_n high at T+3.
REQ-030 RAM write: mem_cs=1, rw=0 at edge T -> dtack_n low at T+2; rom_req unchanged.
REQ-031 ROM fetch: rom_cs=1 at T -> rom_req toggles at T; model acks after 5 cycles -> dtack_n low the edge after ack is seen.
REQ-032 Unmapped access: no select at T -> unmapped pulses 1 cycle at T+64, dtack_n low at T+64.
REQ-033 ROM abort: as_n high 2 cycles into ROM_WAIT, then a new rom_cs access with the ack still late -> no second toggle until the ack arrives, then one toggle and a normal dtack.
REQ-034 Reset mid-access: reset_n low during ACK -> dtack_n high asynchronously, all outputs at reset values, next access behaves normally.
